ssd_value_driver: RTL and testbench



---
 rtl/ssd_value_driver_if.sv | 26 ++
 rtl/ssd_value_driver.sv | 135 +++++++++++++
 tb/tb_ssd_value_driver.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ssd_value_driver_if.sv
// Bundle between a value producer and ssd_value_driver: value handshake in,
// per-digit decoder enables/data out, plus scan status and FSM state for observation.
interface ssd_value_driver_if #(
    parameter int NDIG = 6
);
    // A value transfers on a rising edge where in_valid && in_ready; in_data and
    // in_blink must be stable while in_valid is high, and in_valid does not wait on in_ready.
    logic                 in_valid;
    logic                 in_ready;
    logic [4*NDIG-1:0]    in_data;
    logic                 in_blink;
    logic [NDIG-1:0]      digit_en;
    logic [5*NDIG-1:0]    digit_data;
    logic                 busy;
    logic [1:0]           dbg_state;

    modport master (
        output in_valid, in_data, in_blink,
        input  in_ready, digit_en, digit_data, busy, dbg_state
    );

    modport slave (
        input  in_valid, in_data, in_blink,
        output in_ready, digit_en, digit_data, busy, dbg_state
    );
endinterface

// File: rtl/ssd_value_driver.sv
// Latches a hex value, scans it MS digit first for leading-zero blanking and commits all
// digits atomically to the seven-segment decoders. Blanking is enabled by SSD_LZ_BLANK_EN.
module ssd_value_driver #(
    parameter int NDIG      = 6,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic              clk,
    input  logic              reset,
    ssd_value_driver_if.slave bus
);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_SHOW = 2'd2;

    logic [1:0]          r_state;
    logic [4*NDIG-1:0]   r_shadow;
    logic                r_shadow_blink;
    logic [IW-1:0]       r_idx;
    logic [NDIG-1:0]     r_mask_acc;

    logic [5*NDIG-1:0]   r_digit_data;
    logic [NDIG-1:0]     r_digit_en;
    logic [NDIG-1:0]     r_mask;
    logic                r_blink_mode;
    logic [CW-1:0]       r_cnt;
    logic                r_phase;

    logic                w_ready;
    logic                w_accept;
    logic                w_commit;
    logic                w_blank;
    logic [NDIG-1:0]     w_mask_next;

    assign w_ready  = (r_state != S_SCAN);
    assign w_accept = bus.in_valid && w_ready;
    assign w_commit = (r_state == S_SCAN) && (r_idx == '0);

`ifdef SSD_LZ_BLANK_EN
    logic [3:0] w_nibble;
    logic       r_zero_run;

    assign w_nibble = r_shadow[{r_idx, 2'b00} +: 4];
    assign w_blank  = r_zero_run && (w_nibble == 4'd0) && (r_idx != '0);

    // Stays set only while every digit scanned so far has been zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zero_run <= 1'b1;
        end else if (w_accept) begin
            r_zero_run <= 1'b1;
        end else if (r_state == S_SCAN && w_nibble != 4'd0) begin
            r_zero_run <= 1'b0;
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_mask_next        = r_mask_acc;
        w_mask_next[r_idx] = ~w_blank;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_shadow       <= '0;
            r_shadow_blink <= 1'b0;
            r_idx          <= '0;
            r_mask_acc     <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_SHOW: begin
                    if (w_accept) begin
                        r_shadow       <= bus.in_data;
                        r_shadow_blink <= bus.in_blink;
                        r_idx          <= IDX_MAX;
                        r_mask_acc     <= '0;
                        r_state        <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_mask_acc <= w_mask_next;
                    if (r_idx == '0) begin
                        r_state <= S_SHOW;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Display registers only change at a commit or a blink wrap, so the previous
    // value keeps showing (and blinking) for the whole of a new scan.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digit_data <= '0;
            r_digit_en   <= '0;
            r_mask       <= '0;
            r_blink_mode <= 1'b0;
            r_cnt        <= '0;
            r_phase      <= 1'b1;
        end else if (w_commit) begin
            for (int i = 0; i < NDIG; i++) begin
                r_digit_data[5*i +: 5] <= {1'b0, r_shadow[4*i +: 4]};
            end
            r_mask       <= w_mask_next;
            r_digit_en   <= w_mask_next;
            r_blink_mode <= r_shadow_blink;
            r_cnt        <= '0;
            r_phase      <= 1'b1;
        end else if (r_blink_mode) begin
            if (r_cnt == CNT_MAX) begin
                r_cnt      <= '0;
                r_phase    <= ~r_phase;
                r_digit_en <= r_phase ? '0 : r_mask;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.busy       = (r_state == S_SCAN);
    assign bus.digit_en   = r_digit_en;
    assign bus.digit_data = r_digit_data;
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_ssd_value_driver.sv
// Directed bench for ssd_value_driver with a cycle-level reference model of the display.
module tb_ssd_value_driver;
    localparam int NDIG      = 6;
    localparam int BLINK_DIV = 4;
    localparam int W         = 4 * NDIG;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ssd_value_driver_if #(.NDIG(NDIG)) bus ();

    ssd_value_driver #(.NDIG(NDIG), .BLINK_DIV(BLINK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: what is on the display and how long since it got there.
    logic [W-1:0]    m_disp;
    logic [W-1:0]    m_pend;
    logic            m_blink;
    logic            m_pend_blink;
    logic [NDIG-1:0] m_mask;
    int              m_busy_left;
    int              m_since;
    bit              m_live = 1'b0;

`ifdef SSD_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    function automatic logic [NDIG-1:0] lz_mask(input logic [W-1:0] v);
        logic [NDIG-1:0] m;
        for (int i = 0; i < NDIG; i++) begin
            m[i] = !LZ || (i == 0) || ((v >> (4 * i)) != '0);
        end
        return m;
    endfunction

    function automatic logic [NDIG-1:0] exp_en();
        if (m_blink && (((m_since / BLINK_DIV) % 2) == 1)) return '0;
        return m_mask;
    endfunction

    function automatic logic [5*NDIG-1:0] exp_data();
        logic [5*NDIG-1:0] d;
        for (int i = 0; i < NDIG; i++) begin
            d[5*i +: 5] = {1'b0, m_disp[4*i +: 4]};
        end
        return d;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_disp = '0; m_pend = '0; m_blink = 1'b0; m_pend_blink = 1'b0;
            m_mask = '0; m_busy_left = 0; m_since = 0; m_live = 1'b1;
        end else if (m_live) begin
            m_since++;
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    m_disp  = m_pend;
                    m_mask  = lz_mask(m_pend);
                    m_blink = m_pend_blink;
                    m_since = 0;
                end
            end else if (bus.in_valid) begin
                m_pend       = bus.in_data;
                m_pend_blink = bus.in_blink;
                m_busy_left  = NDIG;
            end
        end
    endtask

    task automatic compare_cycle();
        if (m_live) begin
            check("cyc_en",    64'(bus.digit_en),   64'(exp_en()));
            check("cyc_data",  64'(bus.digit_data), 64'(exp_data()));
            check("cyc_ready", 64'(bus.in_ready),   64'(m_busy_left == 0));
            check("cyc_busy",  64'(bus.busy),       64'(m_busy_left != 0));
        end
    endtask

    task automatic accept(input logic [W-1:0] v, input logic b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        bus.in_blink = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (bus.in_ready !== 1'b1 && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic stimulus();
        int c;
        logic [NDIG-1:0]   en_lit;
        logic [5*NDIG-1:0] d_lit;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_blink = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_en",    64'(bus.digit_en),   64'd0);
        check("rst_data",  64'(bus.digit_data), 64'd0);
        check("rst_ready", 64'(bus.in_ready),   64'd1);
        check("rst_busy",  64'(bus.busy),       64'd0);
        reset = 1'b0;

        accept(24'h001234, 1'b0);
        check("ready_low_1234", 64'(bus.in_ready), 64'd0);
        wait_ready(c);
        check("latency_1234", 64'(c), 64'd6);
        en_lit = LZ ? 6'b001111 : 6'b111111;
        d_lit  = {5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4};
        check("en_1234",   64'(bus.digit_en),   64'(en_lit));
        check("data_1234", 64'(bus.digit_data), 64'(d_lit));

        accept(24'h000000, 1'b0);
        wait_ready(c);
        en_lit = LZ ? 6'b000001 : 6'b111111;
        check("en_zero",   64'(bus.digit_en),   64'(en_lit));
        check("data_zero", 64'(bus.digit_data), 64'd0);

        accept(24'hA0000F, 1'b0);
        wait_ready(c);
        d_lit = {5'hA, 5'd0, 5'd0, 5'd0, 5'd0, 5'hF};
        check("en_a0000f",   64'(bus.digit_en),   64'(6'b111111));
        check("data_a0000f", 64'(bus.digit_data), 64'(d_lit));

        accept(24'h000042, 1'b1);
        wait_ready(c);
        en_lit = LZ ? 6'b000011 : 6'b111111;
        for (int k = 0; k < 12; k++) begin
            check("blink_en", 64'(bus.digit_en), 64'((((k / 4) % 2) == 1) ? 6'b000000 : en_lit));
            @(negedge clk);
        end

        accept(24'h000005, 1'b0);
        wait_ready(c);
        en_lit = LZ ? 6'b000001 : 6'b111111;
        for (int k = 0; k < 8; k++) begin
            check("steady_en", 64'(bus.digit_en), 64'(en_lit));
            @(negedge clk);
        end

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 24'h123456;
        bus.in_blink = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.in_data = W'($urandom);
            if (k == 3) check("scan_hold_data", 64'(bus.digit_data), 64'({25'd0, 5'd5}));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        d_lit = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
        check("scan_ignore_data", 64'(bus.digit_data), 64'(d_lit));
        check("scan_ignore_en",   64'(bus.digit_en),   64'(6'b111111));
        wait_ready(c);

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        accept(24'h000777, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midscan_rst_en",    64'(bus.digit_en),   64'd0);
        check("midscan_rst_data",  64'(bus.digit_data), 64'd0);
        check("midscan_rst_ready", 64'(bus.in_ready),   64'd1);
        check("midscan_rst_busy",  64'(bus.busy),       64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("no_commit_en",   64'(bus.digit_en),   64'd0);
        check("no_commit_data", 64'(bus.digit_data), 64'd0);

        accept(24'h000007, 1'b0);
        wait_ready(c);
        check("latency_7", 64'(c), 64'd6);
        en_lit = LZ ? 6'b000001 : 6'b111111;
        check("en_7",   64'(bus.digit_en),   64'(en_lit));
        check("data_7", 64'(bus.digit_data), 64'd7);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        fork
            begin
                forever begin
                    @(posedge clk);
                    model_step();
                    #1;
                    compare_cycle();
                end
            end
            begin
                stimulus();
            end
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
